rip_bp_table_ctrl: RTL and testbench
====================================

Name: rip_bp_table_ctrl

Overview:
- Sequencer and arbiter for the branch predictor's 2-bit-counter weight table, held in a single-port synchronous RAM.
- After reset, or on a flush request, it walks every entry and writes the initial value.
- In normal operation it shares the one RAM port between fetch-stage prediction lookups and commit-stage counter updates; updates are buffered in a small queue.
- Sits between fetch/commit logic and the table RAM macro.

Parameters:
- INDEX_W, 8, table index width; table holds 2**INDEX_W entries.
- WEIGHT_W, 2, counter width; fixed at 2 (saturating counter).
- INIT_VAL, 2'b01, value written on init (WEAKLY_UNTAKEN).
- UQ_DEPTH, 4, update-queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- flush  in  1  pulse; re-initialise the whole table
- init_done  out  1  high when table is initialised and in RUN
- pred_valid  in  1  lookup request
- pred_index  in  INDEX_W  lookup index
- pred_ready  out  1  lookup accepted when pred_valid && pred_ready
- pred_resp_valid  out  1  lookup result valid
- pred_weight  out  WEIGHT_W  counter read
- pred_taken  out  1  pred_weight[WEIGHT_W-1]
- upd_valid  in  1  update request
- upd_index  in  INDEX_W  index to update
- upd_weight  in  WEIGHT_W  counter value returned with the original prediction
- upd_taken  in  1  resolved branch outcome
- upd_ready  out  1  queue not full
- tbl_en  out  1  RAM access enable
- tbl_we  out  1  RAM write enable
- tbl_addr  out  INDEX_W  RAM address
- tbl_wdata  out  WEIGHT_W  RAM write data
- tbl_rdata  in  WEIGHT_W  RAM read data, valid the cycle after a read

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low on rstn.
- Reset values: state=INIT, init counter=0, queue empty, init_done=0, pred_ready=0, upd_ready=0, pred_resp_valid=0, tbl_en=0, tbl_we=0.
- State INIT:
  - Each cycle: tbl_en=1, tbl_we=1, tbl_addr=counter, tbl_wdata=INIT_VAL; counter increments.
  - After the write to address 2**INDEX_W-1, go to RUN the next cycle. INIT therefore lasts exactly 2**INDEX_W cycles.
  - pred_ready=0 and upd_ready=0 throughout INIT; flush is ignored.
- State RUN: init_done=1; each cycle at most one RAM access.
  - Arbitration: a queued update is issued when the queue is full OR pred_valid=0. Otherwise a pending lookup is issued.
  - pred_ready = !queue_full; it is combinational on queue state only, not on pred_valid.
  - Lookup issue: tbl_en=1, tbl_we=0, tbl_addr=pred_index. The following cycle pred_resp_valid=1, with pred_weight=tbl_rdata.
  - Update issue: pop the queue head and write tbl_addr=index.
    - If taken: wdata = min(weight+1, 3).
    - If not taken: wdata = max(weight-1, 0).
    - No wrap-around: 3+taken stays 3; 0+not-taken stays 0.
  - Idle cycles: tbl_en=0.
- Update queue:
  - FIFO; enqueue when upd_valid && upd_ready, where upd_ready = !full.
  - Simultaneous enqueue and dequeue are allowed when not full; occupancy is unchanged.
  - Entries are written in arrival order.
- Hazards:
  - No read forwarding. A lookup of an index with a queued, unwritten update returns the RAM value. This is the decided behaviour.
  - Two queued updates to the same index are applied independently, last one wins.
- flush in RUN:
  - The next cycle enters INIT with counter=0 and the queue cleared. Pending updates are dropped.
  - Any lookup issued in the flush cycle still produces its response the next cycle.
  - init_done falls the cycle after flush.
- rstn low at any time, including mid-INIT: return to reset values on the next edge and restart INIT from 0.

Test Plan:
- INDEX_W=4; release reset -> exactly 16 writes of 01 to addresses 0..15 in order; init_done rises on cycle 17; pred_ready and upd_ready stay 0 until then.
- In RUN, pred_valid with index 5 -> tbl_addr=5, tbl_we=0; next cycle pred_resp_valid=1 and pred_weight=01, pred_taken=0.
- Updates (3,11,taken), (4,00,not taken), (6,01,taken) with pred_valid=0 -> writes 3:11, 4:00, 6:10 on consecutive cycles (saturation checked).
- Hold pred_valid=1 continuously while sending 4 updates -> queue fills; pred_ready drops and upd_ready drops; next cycle update drains, then pred_ready returns to 1.
- Flush with 2 updates queued -> no writes for those updates; 16-cycle INIT rerun; afterwards lookups return 01.
- Deassert rstn on cycle 7 of INIT -> INIT restarts at address 0 and completes 16 writes from there.

Source files
------------

// File: rtl/rip_bp_table_ctrl.sv
// rtl/rip_bp_table_ctrl.sv - branch-predictor weight table init sequencer and RAM port arbiter
module rip_bp_table_ctrl #(
  parameter int                  INDEX_W  = 8,
  parameter int                  WEIGHT_W = 2,
  parameter logic [WEIGHT_W-1:0] INIT_VAL = WEIGHT_W'(1),
  parameter int                  UQ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  output logic                init_done,
  input  logic                pred_valid,
  input  logic [INDEX_W-1:0]  pred_index,
  output logic                pred_ready,
  output logic                pred_resp_valid,
  output logic [WEIGHT_W-1:0] pred_weight,
  output logic                pred_taken,
  input  logic                upd_valid,
  input  logic [INDEX_W-1:0]  upd_index,
  input  logic [WEIGHT_W-1:0] upd_weight,
  input  logic                upd_taken,
  output logic                upd_ready,
  output logic                tbl_en,
  output logic                tbl_we,
  output logic [INDEX_W-1:0]  tbl_addr,
  output logic [WEIGHT_W-1:0] tbl_wdata,
  input  logic [WEIGHT_W-1:0] tbl_rdata
);

  localparam int                  PW       = $clog2(UQ_DEPTH);
  localparam logic [INDEX_W-1:0]  LAST_IDX = '1;
  localparam logic [WEIGHT_W-1:0] W_MAX    = '1;
  localparam logic [PW:0]         Q_FULL   = (PW+1)'(UQ_DEPTH);
  localparam logic [0:0]          ST_INIT  = 1'b0;
  localparam logic [0:0]          ST_RUN   = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]        count_q, count_d;
  logic               resp_valid_q;

  logic [INDEX_W-1:0]  uq_index  [UQ_DEPTH];
  logic [WEIGHT_W-1:0] uq_weight [UQ_DEPTH];
  logic                uq_taken  [UQ_DEPTH];

  logic                run, in_init, q_full, q_empty;
  logic                issue_upd, issue_pred, enq;
  logic [WEIGHT_W-1:0] head_w, new_w;

  // Outputs are gated by rstn so the RAM sees no access while reset is held.
  assign run       = rstn && (state_q == ST_RUN);
  assign in_init   = rstn && (state_q == ST_INIT);
  assign q_full    = (count_q == Q_FULL);
  assign q_empty   = (count_q == '0);

  assign pred_ready = run && !q_full;
  assign upd_ready  = run && !q_full;
  assign init_done  = (state_q == ST_RUN);

  // Updates win only when the queue is full or fetch is idle; a flush drops them.
  assign issue_upd  = run && !flush && !q_empty && (q_full || !pred_valid);
  assign issue_pred = run && pred_valid && !q_full;
  assign enq        = upd_valid && upd_ready && !flush;

  assign pred_resp_valid = resp_valid_q;
  assign pred_weight     = tbl_rdata;
  assign pred_taken      = tbl_rdata[WEIGHT_W-1];

  assign head_w = uq_weight[rd_ptr_q];

  always_comb begin
    new_w = head_w;
    if (uq_taken[rd_ptr_q]) begin
      if (head_w != W_MAX) new_w = head_w + WEIGHT_W'(1);
    end else begin
      if (head_w != '0) new_w = head_w - WEIGHT_W'(1);
    end
  end

  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = '0;
    if (in_init) begin
      tbl_en    = 1'b1;
      tbl_we    = 1'b1;
      tbl_addr  = cnt_q;
      tbl_wdata = INIT_VAL;
    end else if (issue_upd) begin
      tbl_en    = 1'b1;
      tbl_we    = 1'b1;
      tbl_addr  = uq_index[rd_ptr_q];
      tbl_wdata = new_w;
    end else if (issue_pred) begin
      tbl_en    = 1'b1;
      tbl_addr  = pred_index;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + INDEX_W'(1);
      if (cnt_q == LAST_IDX) state_d = ST_RUN;
    end else if (flush) begin
      state_d  = ST_INIT;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(enq);
      rd_ptr_d = rd_ptr_q + PW'(issue_upd);
      count_d  = count_q + (PW+1)'(enq) - (PW+1)'(issue_upd);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      resp_valid_q <= issue_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      uq_index[wr_ptr_q]  <= upd_index;
      uq_weight[wr_ptr_q] <= upd_weight;
      uq_taken[wr_ptr_q]  <= upd_taken;
    end
  end

endmodule

// File: tb/tb_rip_bp_table_ctrl.sv
// tb/tb_rip_bp_table_ctrl.sv - scoreboard bench for rip_bp_table_ctrl with a behavioural table RAM
module tb_rip_bp_table_ctrl;
  localparam int IW = 4;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          rstn, flush, init_done;
  logic          pred_valid, pred_ready, pred_resp_valid, pred_taken;
  logic [IW-1:0] pred_index;
  logic [WW-1:0] pred_weight;
  logic          upd_valid, upd_taken, upd_ready;
  logic [IW-1:0] upd_index;
  logic [WW-1:0] upd_weight;
  logic          tbl_en, tbl_we;
  logic [IW-1:0] tbl_addr;
  logic [WW-1:0] tbl_wdata, tbl_rdata;

  logic [WW-1:0] mem [16];

  int checks = 0;
  int errors = 0;

  logic [IW+WW-1:0] exp_wr   [$];
  logic [IW-1:0]    exp_rd   [$];
  logic [WW-1:0]    exp_resp [$];
  logic [IW+WW-1:0] mon_wr;
  logic [IW-1:0]    mon_rd;
  logic [WW-1:0]    mon_resp;

  always #5 clk = ~clk;

  rip_bp_table_ctrl #(.INDEX_W(IW), .WEIGHT_W(WW), .INIT_VAL(2'b01), .UQ_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .init_done(init_done),
    .pred_valid(pred_valid), .pred_index(pred_index), .pred_ready(pred_ready),
    .pred_resp_valid(pred_resp_valid), .pred_weight(pred_weight), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_weight(upd_weight),
    .upd_taken(upd_taken), .upd_ready(upd_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata)
  );

  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    checks++;
    errors++;
    $display("FAIL %s got=%0d expected=none at %0t", name, got, $time);
  endtask

  // Monitor: every RAM access and every lookup response is matched against the scoreboard.
  always begin
    @(negedge clk);
    if (rstn) begin
      if (tbl_en && tbl_we) begin
        if (exp_wr.size() == 0) unexpected("write", {tbl_addr, tbl_wdata});
        else begin
          mon_wr = exp_wr.pop_front();
          check("wr_addr", tbl_addr, mon_wr[IW+WW-1:WW]);
          check("wr_data", tbl_wdata, mon_wr[WW-1:0]);
        end
      end
      if (tbl_en && !tbl_we) begin
        if (exp_rd.size() == 0) unexpected("read", tbl_addr);
        else begin
          mon_rd = exp_rd.pop_front();
          check("rd_addr", tbl_addr, mon_rd);
        end
      end
      if (pred_resp_valid) begin
        if (exp_resp.size() == 0) unexpected("resp", pred_weight);
        else begin
          mon_resp = exp_resp.pop_front();
          check("resp_weight", pred_weight, mon_resp);
          check("resp_taken", pred_taken, mon_resp[WW-1]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    for (int i = 0; i < 16; i++) exp_wr.push_back({IW'(i), 2'b01});
  endtask

  task automatic push_wr(input int a, input int d);
    exp_wr.push_back({IW'(a), WW'(d)});
  endtask

  task automatic lookup(input int idx, input int w);
    pred_valid = 1'b1;
    pred_index = IW'(idx);
    exp_rd.push_back(IW'(idx));
    exp_resp.push_back(WW'(w));
    step();
    pred_valid = 1'b0;
  endtask

  task automatic set_upd(input int idx, input int w, input logic t);
    upd_valid  = 1'b1;
    upd_index  = IW'(idx);
    upd_weight = WW'(w);
    upd_taken  = t;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || exp_resp.size() != 0) && n < 50) begin
      step();
      n++;
    end
    check("drain_in_time", n < 50, 1);
    step();
  endtask

  // Counts INIT cycles until init_done; ready must stay low throughout.
  task automatic measure_init(input string name);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (init_done) break;
      n++;
      check("init_pred_ready", pred_ready, 0);
      check("init_upd_ready", upd_ready, 0);
    end
    check(name, n, 16);
    check("run_pred_ready", pred_ready, 1);
    check("run_upd_ready", upd_ready, 1);
    step();
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; pred_valid = 1'b0; pred_index = '0;
    upd_valid = 1'b0; upd_index = '0; upd_weight = '0; upd_taken = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_init_done", init_done, 0);
    check("rst_pred_ready", pred_ready, 0);
    check("rst_upd_ready", upd_ready, 0);
    check("rst_tbl_en", tbl_en, 0);
    check("rst_tbl_we", tbl_we, 0);
    check("rst_resp_valid", pred_resp_valid, 0);
    step();

    // Reset re-asserted partway through INIT: 6 writes, then a full restart from 0.
    for (int i = 0; i < 6; i++) push_wr(i, 1);
    push_init();
    rstn = 1'b1;
    repeat (6) step();
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_tbl_en", tbl_en, 0);
    step();
    rstn = 1'b1;
    measure_init("init_len");
    check("init_writes_left", exp_wr.size(), 0);

    lookup(5, 1);
    drain();

    // Saturating updates with fetch idle.
    push_wr(3, 3); push_wr(4, 0); push_wr(6, 2);
    set_upd(3, 3, 1'b1); step();
    set_upd(4, 0, 1'b0); step();
    set_upd(6, 1, 1'b1); step();
    upd_valid = 1'b0;
    drain();
    lookup(3, 3); lookup(4, 0); lookup(6, 2);
    drain();

    // Continuous lookups starve the queue until it fills.
    push_wr(7, 2); push_wr(8, 1); push_wr(10, 3); push_wr(12, 0);
    pred_valid = 1'b1;
    pred_index = IW'(9);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: set_upd(7, 1, 1'b1);
        1: set_upd(8, 2, 1'b0);
        2: set_upd(10, 3, 1'b1);
        default: set_upd(12, 0, 1'b0);
      endcase
      exp_rd.push_back(IW'(9));
      exp_resp.push_back(2'b01);
      step();
    end
    upd_valid = 1'b0;
    @(negedge clk);
    check("full_pred_ready", pred_ready, 0);
    check("full_upd_ready", upd_ready, 0);
    step();
    exp_rd.push_back(IW'(9));
    exp_resp.push_back(2'b01);
    @(negedge clk);
    check("after_pop_pred_ready", pred_ready, 1);
    check("after_pop_upd_ready", upd_ready, 1);
    step();
    exp_rd.push_back(IW'(9));
    exp_resp.push_back(2'b01);
    step();
    pred_valid = 1'b0;
    drain();
    lookup(7, 2); lookup(8, 1); lookup(10, 3); lookup(12, 0);
    drain();

    // Flush with two updates still queued: they must never reach the RAM.
    pred_valid = 1'b1;
    pred_index = IW'(9);
    set_upd(1, 1, 1'b1);
    exp_rd.push_back(IW'(9)); exp_resp.push_back(2'b01);
    step();
    set_upd(2, 1, 1'b1);
    exp_rd.push_back(IW'(9)); exp_resp.push_back(2'b01);
    step();
    upd_valid = 1'b0;
    flush = 1'b1;
    exp_rd.push_back(IW'(9)); exp_resp.push_back(2'b01);
    push_init();
    step();
    flush = 1'b0;
    pred_valid = 1'b0;
    measure_init("flush_init_len");
    lookup(1, 1); lookup(2, 1);
    drain();

    check("sb_empty", exp_wr.size() + exp_rd.size() + exp_resp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
